// File: rtl/dsp_file_server.sv
// Responder for the DSP file_num/file_active handshake: NUM_FILES circular word buffers plus a host load/drain port.
// Optional feature macro DSP_FILE_OVERWRITE_EN: writes to a full file overwrite the oldest word instead of faulting.
module dsp_file_server #(
    parameter int dw         = 32,
    parameter int NUM_FILES  = 4,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [7:0]    file_num,
    input  logic          file_read,
    input  logic          file_write,
    input  logic [dw-1:0] file_write_data,
    output logic [dw-1:0] file_read_data,
    output logic          file_active,
    output logic [dw-1:0] rd_ptr,
    output logic [dw-1:0] wr_ptr,
    input  logic [7:0]    host_file,
    input  logic          host_write,
    input  logic          host_read,
    input  logic [dw-1:0] host_wdata,
    output logic [dw-1:0] host_rdata,
    output logic          host_ack,
    output logic          error,
    output logic [2:0]    error_status,
    output logic [2:0]    fsm_state
);
    localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int AW = FW + DEPTH_LOG2;
    localparam logic [7:0] NUM_FILES_B = 8'(NUM_FILES);
`ifdef DSP_FILE_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_ACTIVE  = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4,
        S_HOST    = 3'd5
    } state_t;

    state_t          state, next_state;
    logic [dw-1:0]   mem [NUM_FILES << DEPTH_LOG2];
    logic [PW-1:0]   rp [NUM_FILES];
    logic [PW-1:0]   wp [NUM_FILES];

    logic [7:0]      eng_file, hst_file;
    logic            eng_is_read, hst_is_pop;
    logic [dw-1:0]   eng_wdata, hst_wdata;

    logic            op_en, op_read, op_bad, op_empty, op_full;
    logic [7:0]      op_file;
    logic [FW-1:0]   op_idx;
    logic [dw-1:0]   op_wdata, pop_word;
    logic [PW-1:0]   cur_rp, cur_wp;
    logic            do_pop, do_push;
    logic [2:0]      fault;
    logic            req_level;
    logic [FW-1:0]   sel_idx;
    logic            sel_bad;

    // Engine request level that keeps the handshake in HOLD, chosen by the latched direction.
    assign req_level = eng_is_read ? file_read : file_write;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (file_read || file_write)      next_state = S_ACCESS;
                else if (host_write || host_read) next_state = S_HOST;
            end
            S_ACCESS:  next_state = S_ACTIVE;
            S_ACTIVE:  next_state = S_HOLD;
            S_HOLD:    if (!req_level) next_state = S_RELEASE;
            S_RELEASE: next_state = S_IDLE;
            S_HOST:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // One shared access datapath serves both the engine (ACCESS) and the host (HOST).
    always_comb begin
        op_en    = (state == S_ACCESS) || (state == S_HOST);
        op_file  = (state == S_HOST) ? hst_file : eng_file;
        op_read  = (state == S_HOST) ? hst_is_pop : eng_is_read;
        op_wdata = (state == S_HOST) ? hst_wdata : eng_wdata;
        op_bad   = op_file >= NUM_FILES_B;
        op_idx   = op_file[FW-1:0];
        cur_rp   = rp[op_idx];
        cur_wp   = wp[op_idx];
        op_empty = (cur_rp == cur_wp);
        op_full  = (cur_rp[PW-1] != cur_wp[PW-1]) &&
                   (cur_rp[DEPTH_LOG2-1:0] == cur_wp[DEPTH_LOG2-1:0]);
        do_pop   = op_en && !op_bad && op_read && !op_empty;
        do_push  = op_en && !op_bad && !op_read && (!op_full || OVERWRITE);
        pop_word = do_pop ? mem[{op_idx, cur_rp[DEPTH_LOG2-1:0]}] : '0;
        fault    = {op_en && op_bad,
                    op_en && !op_bad && !op_read && op_full && !OVERWRITE,
                    op_en && !op_bad && op_read && op_empty};
    end

    always_ff @(posedge wb_clk) begin
        if (do_push) mem[{op_idx, cur_wp[DEPTH_LOG2-1:0]}] <= op_wdata;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state          <= S_IDLE;
            file_read_data <= '0;
            host_rdata     <= '0;
            host_ack       <= 1'b0;
            error          <= 1'b0;
            error_status   <= '0;
            eng_file       <= '0;
            eng_is_read    <= 1'b0;
            eng_wdata      <= '0;
            hst_file       <= '0;
            hst_is_pop     <= 1'b0;
            hst_wdata      <= '0;
            for (int i = 0; i < NUM_FILES; i++) begin
                rp[i] <= '0;
                wp[i] <= '0;
            end
        end else begin
            state        <= next_state;
            host_ack     <= (state == S_HOST);
            error        <= |fault;
            error_status <= error_status | fault;
            if (state == S_IDLE) begin
                if (file_read || file_write) begin
                    eng_file    <= file_num;
                    eng_is_read <= file_read;
                    eng_wdata   <= file_write_data;
                end else if (host_write || host_read) begin
                    hst_file   <= host_file;
                    hst_is_pop <= host_read;
                    hst_wdata  <= host_wdata;
                end
            end
            if (state == S_ACCESS && eng_is_read) file_read_data <= pop_word;
            if (state == S_HOST && hst_is_pop)    host_rdata     <= pop_word;
            if (do_pop) rp[op_idx] <= cur_rp + PW'(1);
            if (do_push) begin
                wp[op_idx] <= cur_wp + PW'(1);
                // Overwriting a full file discards the oldest word, so the reader skips it.
                if (op_full) rp[op_idx] <= cur_rp + PW'(1);
            end
        end
    end

    assign file_active = (state == S_ACTIVE) || (state == S_HOLD);
    assign fsm_state   = state;
    assign sel_idx     = file_num[FW-1:0];
    assign sel_bad     = file_num >= NUM_FILES_B;
    assign rd_ptr      = sel_bad ? '0 : {{(dw-PW){1'b0}}, rp[sel_idx]};
    assign wr_ptr      = sel_bad ? '0 : {{(dw-PW){1'b0}}, wp[sel_idx]};
endmodule
